// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: word widths, demux select encoding and
// the holding-slot state type.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // in_sel encoding for the 1:2 result demux
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry valid/ready holding register for one demux output, with a
// delivered-word counter. A drain and a load in the same cycle replace the
// held word without a bubble.
module demux_out_slot
  import alu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_free,
  output logic [CW-1:0] o_cnt
);

  slot_state_e   r_state, w_state_nxt;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic          w_drain;

  assign o_valid = (r_state == SLOT_FULL);
  assign w_drain = o_valid & i_ready;
  // A slot can take a word if it is empty or its word leaves this cycle.
  assign o_free  = !o_valid | i_ready;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state: a load always leaves the slot FULL; a lone drain empties it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (w_drain && !i_load) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Payload register; the top only loads when o_free, so a stalled word is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  // Delivered-word counter, wraps naturally at 2^CW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/demux1x2_32b_reg.sv
// Registered 1:2 demux for ALU result routing. Each word goes to out0 or
// out1 by in_sel; each output has its own holding slot so a stalled consumer
// only blocks words aimed at it.
module demux1x2_32b_reg
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = alu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic w_free0, w_free1;
  logic w_acc, w_load0, w_load1;

  // in_ready looks only at the selected slot, never at in_valid
  assign in_ready = (in_sel == SEL_OUT1) ? w_free1 : w_free0;
  assign w_acc    = in_valid & in_ready;
  assign w_load0  = w_acc & (in_sel == SEL_OUT0);
  assign w_load1  = w_acc & (in_sel == SEL_OUT1);

  demux_out_slot #(.DW(DATA_W), .CW(CNT_W)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load0),
    .i_data  (in_data),
    .i_ready (out0_ready),
    .o_valid (out0_valid),
    .o_data  (out0_data),
    .o_free  (w_free0),
    .o_cnt   (cnt0)
  );

  demux_out_slot #(.DW(DATA_W), .CW(CNT_W)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load1),
    .i_data  (in_data),
    .i_ready (out1_ready),
    .o_valid (out1_valid),
    .o_data  (out1_data),
    .o_free  (w_free1),
    .o_cnt   (cnt1)
  );

endmodule

// File: tb/tb_demux1x2_32b_reg.sv
// Scoreboard bench for demux1x2_32b_reg: accepted words are queued per
// output and a negedge monitor pops and compares on every output handshake.
module tb_demux1x2_32b_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  int vectors = 0;
  int errs    = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  demux1x2_32b_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Present one word and hold it until accepted (bounded); the expected
  // output word is queued at the acceptance edge.
  task automatic send(input logic s, input logic [31:0] d, input bit must_be_immediate);
    bit ok = 0;
    in_valid = 1'b1; in_sel = s; in_data = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (s) q1.push_back(d); else q0.push_back(d);
        if (must_be_immediate) chk("in_ready_throughput", 32'(n), 32'd0);
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output handshake must match the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("out0_unexpected", out0_data, 32'hxxxxxxxx);
        else chk("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected", out1_data, 32'hxxxxxxxx);
        else chk("out1_data", out1_data, q1.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: async reset while both slots are full
    send(1'b0, 32'hAAAA5555, 0);
    send(1'b1, 32'h5555AAAA, 0);
    chk("pre_rst_v0", 32'(out0_valid), 32'd1);
    chk("pre_rst_v1", 32'(out1_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_d0", out0_data, 32'd0);
    chk("rst_d1", out1_data, 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    q0.delete(); q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    // 2: one word to each output with both consumers ready
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(1'b0, 32'hFFFFFFFF, 1);
    @(negedge clk);
    chk("t2_d0", out0_data, 32'hFFFFFFFF);
    chk("t2_v0", 32'(out0_valid), 32'd1);
    @(posedge clk); #1;
    send(1'b1, 32'h12345678, 1);
    @(negedge clk);
    chk("t2_d1", out1_data, 32'h12345678);
    @(posedge clk); @(negedge clk);
    chk("t2_cnt0", 32'(cnt0), 32'd1);
    chk("t2_cnt1", 32'(cnt1), 32'd1);
    @(posedge clk); #1;

    // 3: out0 stalled holds its word; out1 still flows
    out0_ready = 1'b0;
    send(1'b0, 32'h00000001, 1);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_d0_hold", out0_data, 32'h00000001);
      chk("t3_v0_hold", 32'(out0_valid), 32'd1);
    end
    @(posedge clk); #1;
    send(1'b1, 32'h10000001, 1);
    @(negedge clk);
    chk("t3_d1", out1_data, 32'h10000001);
    chk("t3_v1", 32'(out1_valid), 32'd1);
    chk("t3_d0_still", out0_data, 32'h00000001);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_cnt0", 32'(cnt0), 32'd2);
    chk("t3_cnt1", 32'(cnt1), 32'd2);
    @(posedge clk); #1;

    // 4: eight back-to-back words alternating select
    for (int i = 0; i < 8; i++)
      send(i[0], 32'hA0000000 + 32'(i), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t4_cnt0", 32'(cnt0), 32'd6);
    chk("t4_cnt1", 32'(cnt1), 32'd6);
    @(posedge clk); #1;

    // 5: drain and load out1 in the same cycle
    out1_ready = 1'b0;
    send(1'b1, 32'h20000000, 1);
    out1_ready = 1'b1;
    send(1'b1, 32'h10000000, 1);
    @(negedge clk);
    chk("t5_v1_nobubble", 32'(out1_valid), 32'd1);
    chk("t5_d1", out1_data, 32'h10000000);
    @(posedge clk); @(negedge clk);
    chk("t5_cnt1", 32'(cnt1), 32'd8);
    @(posedge clk); #1;

    // 6: cnt0 wrap from FFFF to 0000, cnt1 untouched
    rst_n = 1'b0; #1;
    q0.delete(); q1.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 32'h0000BEEF, 1);
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      in_data = 32'(i);
      @(negedge clk);
      if (in_ready) q0.push_back(32'(i));
      else chk("t6_stall", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t6_cnt0_ffff", 32'(cnt0), 32'h0000FFFF);
    chk("t6_cnt1", 32'(cnt1), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 32'hCAFEF00D, 1);
    @(posedge clk); @(negedge clk);
    chk("t6_cnt0_wrap", 32'(cnt0), 32'h00000000);
    chk("t6_cnt1_after", 32'(cnt1), 32'd1);

    // every accepted word must have been delivered
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
